// File: rtl/alu_sequencer.sv
// Operand-entry sequencer for the switch/button ALU front end.
// It debounces the buttons, takes A, then B, then OP in order, strobes start, and captures the ALU result.
module alu_sequencer #(
  parameter int N               = 8,
  parameter int N_OP            = 6,
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 input_clock,
  input  logic                 input_reset,
  input  logic [N-1:0]         input_switches,
  input  logic [N_BUTTONS-1:0] input_buttons,
  input  logic [N-1:0]         input_alu_result,
  output logic [N-1:0]         output_a,
  output logic [N-1:0]         output_b,
  output logic [N_OP-1:0]      output_op,
  output logic                 output_start,
  output logic [N-1:0]         output_result,
  output logic                 output_result_valid,
  output logic                 output_error,
  output logic [2:0]           output_state
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] press;
  logic [N_BUTTONS-1:0] want;
  logic                 any_press;
  logic                 multi_press;
  logic                 accept;
  logic                 reject;
  logic [2:0]           state;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
      logic             sync1;
      logic             sync2;
      logic             level;
      logic [CNT_W-1:0] count;

      always_ff @(posedge input_clock or negedge input_reset) begin
        if (!input_reset) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          level <= 1'b0;
          count <= '0;
        end else begin
          sync1 <= input_buttons[gi];
          sync2 <= sync1;
          if (sync2 == level) begin
            count <= '0;
          end else if (count == CNT_LAST) begin
            level <= sync2;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
      end

      // The press pulse is high during the cycle whose closing edge flips the level to 1.
      // The FSM therefore loads on the same edge that raises the debounced level.
      assign press[gi] = (sync2 != level) && (count == CNT_LAST) && sync2;
    end
  endgenerate

  assign any_press   = |press;
  assign multi_press = |(press & (press - N_BUTTONS'(1)));

  always_comb begin
    want = '0;
    case (state)
      S_A, S_SHOW: want = N_BUTTONS'(1);
      S_B:         want = N_BUTTONS'(2);
      S_OP:        want = N_BUTTONS'(4);
      default:     want = '0;
    endcase
  end

  assign accept = any_press && !multi_press && (press == want);
  assign reject = any_press && !accept;

  always_ff @(posedge input_clock or negedge input_reset) begin
    if (!input_reset) begin
      state               <= S_A;
      output_a            <= '0;
      output_b            <= '0;
      output_op           <= '0;
      output_result       <= '0;
      output_result_valid <= 1'b0;
      output_error        <= 1'b0;
    end else if (state > S_SHOW) begin
      state <= S_A;
    end else if (state == S_EXEC) begin
      output_result       <= input_alu_result;
      output_result_valid <= 1'b1;
      state               <= S_SHOW;
      if (any_press) output_error <= 1'b1;
    end else if (accept) begin
      output_error <= 1'b0;
      case (state)
        S_B: begin
          output_b <= input_switches;
          state    <= S_OP;
        end
        S_OP: begin
          output_op <= input_switches[N_OP-1:0];
          state     <= S_EXEC;
        end
        default: begin
          // S_A or S_SHOW: a new A starts the next sequence, B and OP stay as they were
          output_a            <= input_switches;
          output_result_valid <= 1'b0;
          state               <= S_B;
        end
      endcase
    end else if (reject) begin
      output_error <= 1'b1;
    end
  end

  assign output_start = (state == S_EXEC);
  assign output_state = state;

endmodule
